// File: rtl/mult8_pkg.sv
// Shared widths and FSM state encoding for the 8x8 nibble-based multiplier.
package mult8_pkg;
  localparam int NIB_W  = 4;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/mux2.sv
// Generic 2:1 select, used here to steer operand nibbles.
module mux2 #(
  parameter int W = 4
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         mux_sel,
  output logic [W-1:0] y
);
  assign y = mux_sel ? d1 : d0;
endmodule

// File: rtl/nibble_pp.sv
// Combinational 4x4 -> 8 unsigned partial-product unit.
module nibble_pp
  import mult8_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  output logic [OP_W-1:0]  pp
);
  assign pp = OP_W'(x) * OP_W'(y);
endmodule

// File: rtl/nibble_mult_seq.sv
// Sequential 8x8 unsigned multiplier: one nibble partial product per cycle,
// shifted and accumulated over four RUN cycles.
//
//   state | meaning
//   IDLE  | waiting for start; product holds last result
//   RUN   | accumulating partial product for current step (0..3)
module nibble_mult_seq
  import mult8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);
  state_t            state, state_nxt;
  logic [1:0]        step, step_nxt;
  logic [PROD_W-1:0] acc, acc_nxt;
  logic [OP_W-1:0]   a_q, a_nxt;
  logic [OP_W-1:0]   b_q, b_nxt;
  logic [PROD_W-1:0] prod_nxt;
  logic              done_nxt;

  logic [NIB_W-1:0]  a_nib, b_nib;
  logic [OP_W-1:0]   pp;
  logic [1:0]        shift_nib;
  logic [PROD_W-1:0] pp_sh;

  mux2 #(.W(NIB_W)) u_mux_a (
    .d0      (a_q[3:0]),
    .d1      (a_q[7:4]),
    .mux_sel (step[0]),
    .y       (a_nib)
  );

  mux2 #(.W(NIB_W)) u_mux_b (
    .d0      (b_q[3:0]),
    .d1      (b_q[7:4]),
    .mux_sel (step[1]),
    .y       (b_nib)
  );

  nibble_pp u_pp (
    .x  (a_nib),
    .y  (b_nib),
    .pp (pp)
  );

  // Shift in nibbles equals the count of high nibbles selected this step.
  assign shift_nib = {1'b0, step[0]} + {1'b0, step[1]};
  assign pp_sh     = PROD_W'(pp) << {shift_nib, 2'b00};

  assign busy = (state == RUN);

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    acc_nxt   = acc;
    a_nxt     = a_q;
    b_nxt     = b_q;
    prod_nxt  = product;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          a_nxt     = a;
          b_nxt     = b;
          acc_nxt   = '0;
          step_nxt  = 2'd0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (step == 2'd3) begin
          prod_nxt  = acc + pp_sh;
          done_nxt  = 1'b1;
          step_nxt  = 2'd0;
          state_nxt = IDLE;
        end else begin
          acc_nxt  = acc + pp_sh;
          step_nxt = step + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      step    <= 2'd0;
      acc     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      step    <= step_nxt;
      acc     <= acc_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      product <= prod_nxt;
      done    <= done_nxt;
    end
  end
endmodule

// File: tb/tb_nibble_mult_seq.sv
// Scoreboard bench for nibble_mult_seq: stimulus pushes expected products,
// a negedge monitor pops and compares on every done pulse.
module tb_nibble_mult_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] product;

  logic [15:0] exp_q[$];
  logic [15:0] last_p = 16'h0;
  logic [15:0] exp_v;
  logic        prev_done = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          done_count = 0;
  int          issued = 0;

  nibble_mult_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare at negedge, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_p    = 16'h0;
      prev_done = 1'b0;
    end else if (done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_adjacent: done high on two consecutive cycles at %0t", $time);
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: product=%0d with no operation outstanding", product);
      end else begin
        exp_v = exp_q.pop_front();
        if (product !== exp_v) begin
          errors++;
          $display("FAIL product: got %0d expected %0d at %0t", product, exp_v, $time);
        end
      end
      last_p = product;
      done_count++;
      prev_done = 1'b1;
    end else begin
      checks++;
      if (product !== last_p) begin
        errors++;
        $display("FAIL product_hold: got %0d expected %0d at %0t", product, last_p, $time);
      end
      prev_done = 1'b0;
    end
  end

  task automatic push_exp(input logic [7:0] x, input logic [7:0] y);
    exp_q.push_back(16'(x) * 16'(y));
    issued++;
  endtask

  // Caller is at posedge+#1 with the DUT idle; returns at posedge+#1 of the done cycle.
  task automatic do_op(input logic [7:0] x, input logic [7:0] y);
    a = x; b = y; start = 1'b1;
    push_exp(x, y);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_k3", busy, 1);
    chk("done_early", done, 0);
    @(posedge clk); #1;
    chk("done_k4", done, 1);
    chk("busy_k4", busy, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", done, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = 8'h0; b = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_product", product, 0);

    do_op(8'd3, 8'd5);
    do_op(8'd255, 8'd255);
    do_op(8'hF0, 8'h0F);
    do_op(8'h00, 8'hAB);

    // Restart attempt while busy must be ignored.
    a = 8'd13; b = 8'd11; start = 1'b1;
    push_exp(8'd13, 8'd11);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("ignore_busy_k3", busy, 1);
    chk("ignore_done_k3", done, 0);
    @(posedge clk); #1;
    chk("ignore_done_k4", done, 1);
    @(posedge clk); #1;
    chk("ignore_no_restart", busy, 0);
    chk("ignore_single_done", done, 0);

    // Start held high: two operations back to back.
    a = 8'd7; b = 8'd9; start = 1'b1;
    push_exp(8'd7, 8'd9);
    push_exp(8'd200, 8'd3);
    @(posedge clk); #1;
    a = 8'd200; b = 8'd3;
    wait_done();
    @(posedge clk); #1;
    start = 1'b0;
    chk("held_second_accept", busy, 1);
    wait_done();
    @(posedge clk); #1;
    chk("held_idle", busy, 0);

    // Reset mid-run clears everything and cancels the result.
    a = 8'd100; b = 8'd100; start = 1'b1;
    push_exp(8'd100, 8'd100);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_product", product, 0);
    chk("rst_done", done, 0);
    exp_q.delete();
    issued--;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'd12, 8'd12);

    for (int i = 0; i < 1000; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    chk("done_count", done_count, issued);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
